// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  // Fetch port
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  // Data port
  logic              d_read;
  logic              d_write;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  // Hazard outputs
  logic              stall_if;
  logic              stall_mem;
  // Memory side
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_err;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, d_rdata, d_done, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata, bus_err
  );

  // Environment view (pipeline plus memory)
  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, d_rdata, d_done, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// MEM has fixed priority; IF is forced after STARVE_LIMIT consecutive MEM grants.
module mem_port_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned WaitW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WaitW-1:0]   WaitLast  = WaitW'(MAX_WAIT - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e              state_q;
  logic [WaitW-1:0]    wait_q;
  logic [StarveW-1:0]  starve_q;
  logic                mem_en_q, mem_we_q, if_done_q, d_done_q, bus_err_q;
  logic [DATA_W-1:0]   mem_addr_q, mem_wdata_q, if_rdata_q, d_rdata_q;

  logic d_req;
  logic if_live, d_live;

  // A port whose done is high this cycle is already served; ignoring it avoids a re-access.
  assign d_req   = bus.d_read | bus.d_write;
  assign if_live = bus.if_req & ~if_done_q;
  assign d_live  = d_req & ~d_done_q;

  // Combinational stalls release the pipeline exactly in the done cycle.
  assign bus.stall_if  = bus.if_req & ~if_done_q;
  assign bus.stall_mem = d_req & ~d_done_q;

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.bus_err   = bus_err_q;

  // Arbitration, memory handshake, timeout and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (if_live && (starve_q == StarveMax || !d_live)) begin
            state_q    <= StBusyI;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
            wait_q     <= '0;
            starve_q   <= '0;
          end else if (d_live) begin
            state_q     <= StBusyD;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.d_write;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            wait_q      <= '0;
            if (if_live && starve_q != StarveMax) starve_q <= starve_q + StarveW'(1);
          end
        end
        StBusyI, StBusyD: begin
          if (bus.mem_ready || wait_q == WaitLast) begin
            // A timed-out access still completes towards the requester, with zero data.
            if (!bus.mem_ready) bus_err_q <= 1'b1;
            if (state_q == StBusyI) begin
              if_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
              if_done_q  <= 1'b1;
            end else begin
              d_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
              d_done_q  <= 1'b1;
            end
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= StIdle;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run,
// all compared cycle by cycle against a behavioural reference model.
module tb_mem_port_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 15;
  localparam int unsigned SL = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .DATA_W      (DW),
    .MAX_WAIT    (MW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and expected outputs.
  int owner = 0;
  int waited = 0;
  int starve = 0;
  logic          e_en = 1'b0, e_we = 1'b0, e_idone = 1'b0, e_ddone = 1'b0, e_err = 1'b0;
  logic [DW-1:0] e_addr = '0, e_wdata = '0, e_irdata = '0, e_drdata = '0;

  task automatic model_reset();
    owner = 0; waited = 0; starve = 0;
    e_en = 0; e_we = 0; e_idone = 0; e_ddone = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit ir, dr;
    logic [DW-1:0] data;
    ir = bus.if_req && !e_idone;
    dr = (bus.d_read || bus.d_write) && !e_ddone;
    if (reset) begin
      model_reset();
      return;
    end
    e_idone = 0;
    e_ddone = 0;
    if (owner == 0) begin
      if (ir && (starve == SL || !dr)) begin
        owner = 1; e_en = 1; e_we = 0; e_addr = bus.if_addr; waited = 0; starve = 0;
      end else if (dr) begin
        owner = 2; e_en = 1; e_we = bus.d_write; e_addr = bus.d_addr; e_wdata = bus.d_wdata;
        waited = 0;
        if (ir && starve < SL) starve = starve + 1;
      end
    end else if (bus.mem_ready || waited == MW - 1) begin
      data = bus.mem_ready ? bus.mem_rdata : '0;
      if (!bus.mem_ready) e_err = 1;
      if (owner == 1) begin e_irdata = data; e_idone = 1; end
      else begin e_drdata = data; e_ddone = 1; end
      owner = 0; e_en = 0; e_we = 0;
    end else begin
      waited = waited + 1;
    end
  endtask

  // One clock: check stalls before the edge, then all registered outputs after it.
  task automatic step();
    logic exp_si, exp_sm;
    logic [132:0] obs, exp;
    #1;
    exp_si = bus.if_req & ~e_idone;
    exp_sm = (bus.d_read | bus.d_write) & ~e_ddone;
    checks++;
    if ({bus.stall_if, bus.stall_mem} !== {exp_si, exp_sm}) begin
      errors++;
      $display("FAIL stall t=%0t got if/mem=%b%b expected=%b%b", $time,
               bus.stall_if, bus.stall_mem, exp_si, exp_sm);
    end
    model_step();
    @(posedge clock);
    #1;
    obs = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_done, bus.d_done,
           bus.if_rdata, bus.d_rdata, bus.bus_err};
    exp = {e_en, e_we, e_addr, e_wdata, e_idone, e_ddone, e_irdata, e_drdata, e_err};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL outputs t=%0t got=%h expected=%h", $time, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 0; bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.if_done, bus.d_done, bus.bus_err, bus.mem_addr,
         bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_state got en=%b we=%b addr=%h rdata=%h/%h err=%b required all 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.if_rdata, bus.d_rdata, bus.bus_err);
    end
    reset = 0;
    step();
  endtask

  task automatic test_fetch();
    bus.if_req = 1; bus.if_addr = 32'h40; bus.mem_ready = 0;
    #1;
    checks++;
    if (bus.stall_if !== 1'b1) begin
      errors++; $display("FAIL fetch_stall_c0 got=%b required=1", bus.stall_if);
    end
    step();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.stall_if} !== {1'b1, 1'b0, 32'h40, 1'b1})
    begin
      errors++;
      $display("FAIL fetch_c1 got en=%b we=%b addr=%h stall=%b required 1 0 00000040 1",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.stall_if);
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'h20080005;
    step();
    checks++;
    if ({bus.if_done, bus.if_rdata, bus.stall_if} !== {1'b1, 32'h20080005, 1'b0}) begin
      errors++;
      $display("FAIL fetch_c2 got done=%b rdata=%h stall=%b required 1 20080005 0",
               bus.if_done, bus.if_rdata, bus.stall_if);
    end
    bus.if_req = 0; bus.mem_ready = 0;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    bus.if_req = 1; bus.if_addr = 32'h44; bus.d_read = 1; bus.d_addr = 32'h100;
    bus.mem_ready = 0;
    step();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL simul_dgrant got en=%b we=%b addr=%h required 1 0 00000100",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ready = 1; bus.mem_rdata = $urandom;
    step();
    checks++;
    if ({bus.d_done, bus.if_done, bus.stall_if} !== 3'b101) begin
      errors++;
      $display("FAIL simul_ddone got d_done=%b if_done=%b stall_if=%b required 1 0 1",
               bus.d_done, bus.if_done, bus.stall_if);
    end
    bus.d_read = 0;
    step();
    checks++;
    if ({bus.mem_en, bus.mem_addr, bus.stall_if} !== {1'b1, 32'h44, 1'b1}) begin
      errors++;
      $display("FAIL simul_igrant got en=%b addr=%h stall_if=%b required 1 00000044 1",
               bus.mem_en, bus.mem_addr, bus.stall_if);
    end
    step();
    checks++;
    if (bus.if_done !== 1'b1) begin
      errors++; $display("FAIL simul_idone got=%b required=1", bus.if_done);
    end
    bus.if_req = 0; bus.mem_ready = 0;
    step();
  endtask

  task automatic test_starvation();
    int dg;
    bit got_i;
    dg = 0; got_i = 0;
    bus.if_req = 1; bus.if_addr = 32'h400; bus.d_read = 1; bus.d_write = 0;
    bus.d_addr = 32'h200; bus.mem_ready = 1; bus.mem_rdata = 32'h0BADF00D;
    // IF steps back in each data done cycle, so MEM keeps winning until the override fires.
    for (int c = 0; c < 40 && !got_i; c++) begin
      step();
      if (bus.mem_en && bus.mem_addr == 32'h400) got_i = 1;
      else if (bus.mem_en && bus.mem_addr == 32'h200) dg++;
      bus.if_req = bus.d_done ? 1'b0 : 1'b1;
    end
    checks++;
    if (!got_i || dg != SL) begin
      errors++;
      $display("FAIL starve_grants got d_grants=%0d i_granted=%0d required %0d 1", dg, got_i, SL);
    end
    step();
    checks++;
    if (bus.if_done !== 1'b1) begin
      errors++; $display("FAIL starve_idone got=%b required=1", bus.if_done);
    end
    bus.if_req = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.d_done) break;
    end
    bus.d_read = 0; bus.mem_ready = 0;
    step();
  endtask

  task automatic test_store();
    int dn;
    dn = 0;
    bus.d_write = 1; bus.d_addr = 32'h8; bus.d_wdata = 32'hDEADBEEF;
    bus.mem_ready = 0; bus.mem_rdata = 32'h5A5A1234;
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
          {1'b1, 1'b1, 32'h8, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL store_hold k=%0d got en=%b we=%b addr=%h wdata=%h required 1 1 8 deadbeef",
                 k, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      bus.mem_ready = (k == 4);
      step();
      if (bus.d_done) dn++;
    end
    bus.d_write = 0; bus.mem_ready = 0;
    step();
    if (bus.d_done || bus.mem_en) dn = dn + 10;
    checks++;
    if (dn != 1) begin
      errors++; $display("FAIL store_done_once got score=%0d required=1", dn);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    checks++;
    if (bus.bus_err !== 1'b0) begin
      errors++; $display("FAIL timeout_pre_err got=%b required=0", bus.bus_err);
    end
    bus.d_read = 1; bus.d_addr = 32'h20; bus.mem_ready = 0; bus.mem_rdata = 32'hFFFFFFFF;
    step();
    for (int c = 0; c < 20 && !bus.d_done; c++) begin
      if (bus.mem_en) n++;
      step();
    end
    checks++;
    if (n != MW || bus.d_done !== 1'b1 || bus.d_rdata !== '0 || bus.bus_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout got en_cycles=%0d done=%b rdata=%h err=%b required %0d 1 0 1",
               n, bus.d_done, bus.d_rdata, bus.bus_err, MW);
    end
    bus.d_read = 0;
    step(); step(); step();
    checks++;
    if (bus.bus_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky got=%b required=1", bus.bus_err);
    end
  endtask

  task automatic test_reset_mid();
    bus.d_read = 1; bus.d_addr = 32'h30; bus.mem_ready = 0;
    step();
    step();
    reset = 1;
    step();
    checks++;
    if ({bus.mem_en, bus.d_done, bus.bus_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid got en=%b d_done=%b err=%b required 0 0 0",
               bus.mem_en, bus.d_done, bus.bus_err);
    end
    reset = 0; bus.d_read = 0;
    step();
  endtask

  task automatic test_random();
    int kind;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      step();
      if (bus.if_done) bus.if_req = 0;
      else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1; bus.if_addr = $urandom;
      end
      if (bus.d_done) begin
        bus.d_read = 0; bus.d_write = 0;
      end else if (!(bus.d_read || bus.d_write) && $urandom_range(0, 1) == 0) begin
        kind = $urandom_range(0, 2);
        bus.d_read  = (kind != 1);
        bus.d_write = (kind != 0);
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
    end
    reset = 0;
    idle_inputs();
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
